// File: rtl/emu_ckpt_pkg.sv
// Shared types and sizing helpers for the checkpoint sequencer.
package emu_ckpt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_FF,
    ST_RLEAD,
    ST_RAM,
    ST_RTAIL,
    ST_SETTLE
  } state_e;

  typedef enum logic {
    OP_SAVE    = 1'b0,
    OP_RESTORE = 1'b1
  } op_e;

  localparam int DEF_FF_WORDS  = 16;
  localparam int DEF_MEM_WORDS = 256;
  localparam int SLOT_WORDS    = DEF_FF_WORDS + DEF_MEM_WORDS;

  function automatic int slot_words(input int ff_words, input int mem_words);
    return ff_words + mem_words;
  endfunction

endpackage

// File: rtl/emu_ckpt_store.sv
// Snapshot store: simple dual-port synchronous RAM, one write and one read port, 1-cycle read latency.
module emu_ckpt_store #(
  parameter int DW    = 64,
  parameter int DEPTH = 1088,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/emu_ckpt_ctrl.sv
// Checkpoint sequencer: halts the emulated DUT and moves FF/RAM scan-chain snapshots to and from on-chip slots.
module emu_ckpt_ctrl
  import emu_ckpt_pkg::*;
#(
  parameter  int DW        = 64,
  parameter  int FF_WORDS  = 16,
  parameter  int MEM_WORDS = 256,
  parameter  int N_SLOTS   = 4,
  parameter  int RAM_LEAD  = 2,
  localparam int SL_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [SL_W-1:0]    cmd_slot,
  input  logic               auto_en,
  input  logic [31:0]        auto_period,
  input  logic               host_halt,
  output logic               emu_halt,
  output logic [63:0]        cycle,
  output logic               ff_scan,
  output logic               ff_dir,
  output logic [DW-1:0]      ff_sdi,
  input  logic [DW-1:0]      ff_sdo,
  output logic               ram_scan,
  output logic               ram_dir,
  output logic [DW-1:0]      ram_sdi,
  input  logic [DW-1:0]      ram_sdo,
  output logic               done,
  output logic               err,
  output logic [N_SLOTS-1:0] slot_valid
);

  localparam int SW    = slot_words(FF_WORDS, MEM_WORDS);
  localparam int DEPTH = N_SLOTS * SW;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(SW + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [SL_W-1:0]    slot_q, slot_d, auto_slot_q, auto_slot_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [63:0]        cycle_q, cycle_d;
  logic [31:0]        run_q, run_d;
  logic [N_SLOTS-1:0] valid_q, valid_d;
  logic               done_q, done_d, err_q, err_d;
  logic [63:0]        slot_cyc_q [N_SLOTS];

  logic               host_go, auto_go;
  op_e                go_op;
  logic [SL_W-1:0]    go_slot;
  logic [CW-1:0]      idx, rd_idx;
  logic [AW-1:0]      base, waddr, raddr;
  logic               we;
  logic [DW-1:0]      wdata, rd_data;

  // Host command wins a same-cycle tie; the auto request is simply dropped.
  assign host_go = cmd_valid && (state_q == ST_IDLE);
  assign auto_go = (state_q == ST_IDLE) && auto_en && (auto_period != 32'd0) &&
                   (run_q >= auto_period - 32'd1);
  assign go_op   = host_go ? op_e'(cmd_op) : OP_SAVE;
  assign go_slot = host_go ? cmd_slot : auto_slot_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    slot_d      = slot_q;
    auto_slot_d = auto_slot_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cycle_d     = emu_halt ? cycle_q : cycle_q + 64'd1;
    run_d       = (!emu_halt && (run_q != '1)) ? run_q + 32'd1 : run_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_go || auto_go) begin
          run_d  = '0;
          op_d   = go_op;
          slot_d = go_slot;
          if (!host_go)
            auto_slot_d = (auto_slot_q == SL_W'(N_SLOTS - 1)) ? '0 : auto_slot_q + 1'b1;
          if ((go_op == OP_RESTORE) && !valid_q[go_slot]) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_HALT;
            cnt_d   = '0;
            if (go_op == OP_SAVE) valid_d[go_slot] = 1'b0;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_FF;
        cnt_d   = '0;
      end
      ST_FF: begin
        if (cnt_q == CW'(FF_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = ((op_q == OP_SAVE) && (RAM_LEAD != 0)) ? ST_RLEAD : ST_RAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RLEAD: begin
        if (cnt_q == CW'(RAM_LEAD - 1)) begin
          cnt_d   = '0;
          state_d = ST_RAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RAM: begin
        if (cnt_q == CW'(MEM_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = (op_q == OP_RESTORE) ? ST_RTAIL : ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RTAIL: state_d = ST_SETTLE;
      ST_SETTLE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (op_q == OP_SAVE) valid_d[slot_q] = 1'b1;
        else                 cycle_d = slot_cyc_q[slot_q];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SAVE;
      slot_q      <= '0;
      auto_slot_q <= '0;
      cnt_q       <= '0;
      cycle_q     <= '0;
      run_q       <= '0;
      valid_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      slot_q      <= slot_d;
      auto_slot_q <= auto_slot_d;
      cnt_q       <= cnt_d;
      cycle_q     <= cycle_d;
      run_q       <= run_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == ST_SETTLE) && (op_q == OP_SAVE)) slot_cyc_q[slot_q] <= cycle_q;
  end

  // Reads run one word ahead of the scan position so restore data is ready on every scan cycle.
  assign idx    = (state_q == ST_RAM) ? CW'(FF_WORDS) + cnt_q : cnt_q;
  assign rd_idx = (state_q == ST_HALT) ? '0 :
                  (idx >= CW'(SW - 1)) ? CW'(SW - 1) : idx + 1'b1;
  assign base   = AW'(32'(slot_q) * SW);
  assign waddr  = base + AW'(idx);
  assign raddr  = base + AW'(rd_idx);
  assign we     = (op_q == OP_SAVE) && ((state_q == ST_FF) || (state_q == ST_RAM));
  assign wdata  = (state_q == ST_FF) ? ff_sdo : ram_sdo;

  emu_ckpt_store #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_store (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rd_data)
  );

  // Saving recirculates the FF chain so the DUT resumes with its state intact.
  assign ff_scan    = (state_q == ST_FF);
  assign ff_dir     = ff_scan && (op_q == OP_RESTORE);
  assign ff_sdi     = !ff_scan ? '0 : ff_dir ? rd_data : ff_sdo;
  assign ram_scan   = (state_q == ST_RLEAD) || (state_q == ST_RAM) || (state_q == ST_RTAIL);
  assign ram_dir    = ram_scan && (op_q == OP_RESTORE);
  assign ram_sdi    = ram_dir ? rd_data : '0;
  assign emu_halt   = host_halt || (state_q != ST_IDLE);
  assign cmd_ready  = (state_q == ST_IDLE);
  assign cycle      = cycle_q;
  assign done       = done_q;
  assign err        = err_q;
  assign slot_valid = valid_q;

endmodule
